// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
// Groups the ID-stage, issue, writeback and stall signals of the hazard
// scoreboard into one bundle.
//   master : pipeline side; drives ID/issue/writeback and reads the stall lines
//   slave  : scoreboard side; reads ID/issue/writeback and drives the stall lines
// Signals:
//   id_valid, id_rden[NREAD], id_raddr[NREAD*AW], id_wen, id_wdest[AW]
//   issue_fire, issue_lat[LATW], wb_valid, wb_dest[AW]
//   block_id, block_if, raw_wait[NREAD], waw_full, stall_cycles[CNTW], sb_err
interface hazard_scoreboard_if #(
  parameter int NREAD = 2,
  parameter int AW    = 5,
  parameter int LATW  = 3,
  parameter int CNTW  = 32
);
  logic                  id_valid;
  logic [NREAD-1:0]      id_rden;
  logic [NREAD*AW-1:0]   id_raddr;
  logic                  id_wen;
  logic [AW-1:0]         id_wdest;
  logic                  issue_fire;
  logic [LATW-1:0]       issue_lat;
  logic                  wb_valid;
  logic [AW-1:0]         wb_dest;
  logic                  block_id;
  logic                  block_if;
  logic [NREAD-1:0]      raw_wait;
  logic                  waw_full;
  logic [CNTW-1:0]       stall_cycles;
  logic                  sb_err;

  modport master (
    output id_valid, id_rden, id_raddr, id_wen, id_wdest,
    output issue_fire, issue_lat, wb_valid, wb_dest,
    input  block_id, block_if, raw_wait, waw_full, stall_cycles, sb_err
  );

  modport slave (
    input  id_valid, id_rden, id_raddr, id_wen, id_wdest,
    input  issue_fire, issue_lat, wb_valid, wb_dest,
    output block_id, block_if, raw_wait, waw_full, stall_cycles, sb_err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Scoreboard-based RAW/WAW hazard unit for the ID stage. Every register keeps
// an outstanding-write count and a countdown until its youngest write becomes
// forwardable; ID is stalled while any enabled source still waits or while
// the destination's outstanding counter is saturated.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous active-high, clears the whole scoreboard
//   bus   : hazard_scoreboard_if slave modport (ID/issue/writeback inputs,
//           stall, debug and counter outputs)
module hazard_scoreboard #(
  parameter int NREAD = 2,
  parameter int AW    = 5,
  parameter int LATW  = 3,
  parameter int INFW  = 2,
  parameter int CNTW  = 32
) (
  input  logic             clk,
  input  logic             reset,
  hazard_scoreboard_if.slave bus
);

  localparam int NREG = 1 << AW;

  logic [INFW-1:0] out_cnt [NREG];
  logic [LATW-1:0] tmr     [NREG];

  logic [NREAD-1:0] raw_vec;
  logic             waw_sat;
  logic             block;
  logic             do_issue;
  logic             do_retire;
  logic             err_now;
  logic [NREG-1:0]  ld_hit;
  logic [NREG-1:0]  rt_hit;
  logic [CNTW-1:0]  stall_cnt;
  logic             err_flag;

  // A source waits only while its register has a write in flight whose
  // result is not yet forwardable; register 0 is never a hazard.
  always_comb begin
    raw_vec = '0;
    for (int i = 0; i < NREAD; i++) begin
      raw_vec[i] = bus.id_valid & bus.id_rden[i]
                 & (bus.id_raddr[i*AW +: AW] != '0)
                 & (out_cnt[bus.id_raddr[i*AW +: AW]] != '0)
                 & (tmr[bus.id_raddr[i*AW +: AW]] != '0);
    end
  end

  // A writer cannot issue when its destination counter would overflow.
  always_comb begin
    waw_sat = bus.id_valid & bus.id_wen & (bus.id_wdest != '0)
            & (out_cnt[bus.id_wdest] == {INFW{1'b1}});
    block   = (|raw_vec) | waw_sat;
  end

  // One-hot load/retire selects; an issue_fire while stalled is dropped.
  always_comb begin
    do_issue  = bus.issue_fire & bus.id_valid & ~block & bus.id_wen & (bus.id_wdest != '0);
    do_retire = bus.wb_valid & (bus.wb_dest != '0);
    err_now   = do_retire & (out_cnt[bus.wb_dest] == '0);
    ld_hit    = '0;
    rt_hit    = '0;
    if (do_issue) ld_hit[bus.id_wdest] = 1'b1;
    if (do_retire && !err_now) rt_hit[bus.wb_dest] = 1'b1;
  end

  // Per-register update. Issue and a valid retire to the same register
  // cancel in the counter while the new writer still takes over the timer.
  // A retire to an idle register is ignored, so an issue alongside it still
  // counts. The timer is cleared once the last outstanding write retires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        out_cnt[r] <= '0;
        tmr[r]     <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (ld_hit[r]) begin
          tmr[r] <= bus.issue_lat;
          if (!rt_hit[r]) out_cnt[r] <= out_cnt[r] + 1'b1;
        end else if (rt_hit[r]) begin
          out_cnt[r] <= out_cnt[r] - 1'b1;
          if (out_cnt[r] == INFW'(1))   tmr[r] <= '0;
          else if (tmr[r] != '0)        tmr[r] <= tmr[r] - 1'b1;
        end else if (tmr[r] != '0) begin
          tmr[r] <= tmr[r] - 1'b1;
        end
      end
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                stall_cnt <= '0;
    else if (block && stall_cnt != {CNTW{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
  end

  // Sticky flag for retirements with nothing outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err_flag <= 1'b0;
    else if (err_now) err_flag <= 1'b1;
  end

  assign bus.raw_wait     = raw_vec;
  assign bus.waw_full     = waw_sat;
  assign bus.block_id     = block;
  assign bus.block_if     = block;
  assign bus.stall_cycles = stall_cnt;
  assign bus.sb_err       = err_flag;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised RAW/WAW hazard unit for the ID stage, driven by a per-register scoreboard instead of fixed EXE/MEM/WB destination compares. Each register tracks how many writes are in flight and how many cycles remain before the youngest write can be forwarded. ID is stalled while any enabled source is still waiting. Multi-cycle producers (load, mul, div) use variable latency and need no extra compare logic. Sits beside the ID stage and drives the IF/ID stall lines.

## Interface
- NREAD, 2: number of ID source-register read ports.
- AW, 5: register address width; 2**AW registers, register 0 never tracked.
- LATW, 3: width of the forward-latency field; max latency 2**LATW-1.
- INFW, 2: width of the per-register outstanding-write counter; max in-flight writes per register is 2**INFW-1.
- CNTW, 32: width of the stall-cycle performance counter.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- id_valid  in  1  ID stage holds a valid instruction.
- id_rden  in  NREAD  per-port read enable.
- id_raddr  in  NREAD*AW  source addresses, port i at bits [i*AW +: AW].
- id_wen  in  1  ID instruction writes a register.
- id_wdest  in  AW  destination of the ID instruction.
- issue_fire  in  1  ID instruction moves to EXE this cycle.
- issue_lat  in  LATW  cycles after issue before the result can be forwarded; 0 means it is forwardable from EXE.
- wb_valid  in  1  a register write retires this cycle.
- wb_dest  in  AW  retiring destination.
- block_id  out  1  stall ID.
- block_if  out  1  stall IF; always equals block_id.
- raw_wait  out  NREAD  per-port RAW stall cause (debug).
- waw_full  out  1  stall caused by a saturated outstanding counter.
- stall_cycles  out  CNTW  saturating count of cycles with block_id=1.
- sb_err  out  1  sticky; set when a retirement arrives with no matching outstanding write.

## Operation
- Per-register state for r = 1..2**AW-1:
  - out[r]: INFW-bit outstanding-write count.
  - tmr[r]: LATW-bit countdown.
- Register r is busy when out[r] != 0.
- raw_wait[i] = id_valid & id_rden[i] & (raddr_i != 0) & (out[raddr_i] != 0) & (tmr[raddr_i] != 0).
- waw_full = id_valid & id_wen & (id_wdest != 0) & (out[id_wdest] == 2**INFW-1).
- block_id = |raw_wait | waw_full. Purely combinational from current state and ID inputs.
- Effective issue: iss = issue_fire & id_valid & !block_id. issue_fire while stalled is ignored.
- On iss with id_wen and id_wdest != 0:
  - out[d] increments.
  - tmr[d] loads issue_lat. The youngest writer always owns the timer.
- Every edge, each nonzero tmr[r] that is not being loaded decrements by 1.
- On wb_valid with wb_dest != 0:
  - out[wb_dest] decrements if nonzero.
  - If out is already 0, the retirement is ignored and sb_err is set.
  - When out reaches 0, tmr is cleared.
- Issue and retire to the same register in one cycle: out is unchanged and tmr loads issue_lat.
- Register 0: never busy, never stalls, never counted.
- stall_cycles increments on every edge with block_id=1 and holds at all-ones.
- Reads are checked only against registered state. The issuing instruction never hazards against itself.

## Timing
- Reset values: all out=0, all tmr=0, stall_cycles=0, sb_err=0. With that state, block_id=block_if=0, raw_wait=0 and waw_full=0.
- Reset asserted mid-operation clears the scoreboard immediately, not on the next edge. In-flight retirements after reset deassertion then raise sb_err. This is a legal, diagnosable outcome.
- Producer issued at edge t with latency L, consumer in ID from cycle t+1:
  - The consumer stalls in cycles t+1 .. t+L.
  - It issues in cycle t+1+L.
  - L=0 gives no stall; L=1 is a classic load-use one-cycle stall.
- block_id responds in the same cycle as the ID inputs; there is no registered stall path.
- WAW: a younger issue to a busy register restarts the timer. The older retirement only decrements out and does not clear tmr while out stays nonzero.

## Test plan
- Load-use: issue dest r5 with lat=1, next ID reads r5 on port 0 -> block_id=1 for exactly 1 cycle, raw_wait=2'b01, stall_cycles=1.
- Divider: issue dest r7 with lat=6, ID reads r7 on port 1 -> 6 stall cycles, raw_wait=2'b10, release in cycle t+7.
- Zero and forwardable: ID reads r0 while r0 was "issued" with lat=5 -> no stall. Issue r3 with lat=0 and read r3 -> no stall.
- WAW saturation: INFW=2, issue three writes to r9 with no retirement -> out[r9]=3. A fourth ID writer to r9 -> waw_full=1 and block_id=1 until one wb to r9 arrives.
- Same-cycle issue and retire to r4 with out[r4]=1 -> out stays 1 and tmr[r4]=issue_lat. A wb to r2 with out[r2]=0 -> sb_err=1 and stays set.
- Asynchronous reset asserted mid-cycle while stalled -> block_id drops to 0 without a clock edge, and stall_cycles reads 0.
